ydriver_scan: RTL and testbench



---
 rtl/ydriver_pkg.sv | 12 +
 rtl/ydriver_scan_lvl.sv | 22 ++
 rtl/ydriver_scan.sv | 108 ++++++++++
 tb/tb_ydriver_scan.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ydriver_pkg.sv
// Shared definitions for the LCD row (Y) scan driver: drive-level codes and defaults.
package ydriver_pkg;

    // Per-row drive codes, {sel, level}
    localparam logic [1:0] LVL_NSEL_LO = 2'b00;
    localparam logic [1:0] LVL_NSEL_HI = 2'b01;
    localparam logic [1:0] LVL_SEL_LO  = 2'b10;
    localparam logic [1:0] LVL_SEL_HI  = 2'b11;

    localparam int ROWS_DEFAULT = 144;

endpackage

// File: rtl/ydriver_scan_lvl.sv
// Per-row level encoder: maps (select, frame polarity) to the 2-bit code for the level shifter.
module ydriver_scan_lvl
    import ydriver_pkg::*;
(
    input  logic       sel,
    input  logic       fr_q,
    output logic [1:0] lvl
);

    // Non-selected rows sit at the opposite polarity of the selected row.
    always_comb begin
        lvl = LVL_NSEL_HI;
        unique case ({sel, fr_q})
            2'b00:   lvl = LVL_NSEL_HI;
            2'b01:   lvl = LVL_NSEL_LO;
            2'b10:   lvl = LVL_SEL_LO;
            2'b11:   lvl = LVL_SEL_HI;
            default: lvl = LVL_NSEL_HI;
        endcase
    end

endmodule

// File: rtl/ydriver_scan.sv
// LCD common/row scan driver: a start token walks a ROWS-stage shift register on each row
// strobe; selects are gated by a non-overlap gap and a registered blank.
module ydriver_scan
    import ydriver_pkg::*;
#(
    parameter int ROWS   = ROWS_DEFAULT,
    parameter int NONOVL = 1,
    parameter int IDXW   = $clog2(ROWS)
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic              st,
    input  logic              shift_en,
    input  logic              fr,
    input  logic              dir,
    input  logic              blank,
    output logic [ROWS-1:0]   row_sel,
    output logic [2*ROWS-1:0] lane_lvl,
    output logic [IDXW-1:0]   row_idx,
    output logic              busy,
    output logic              scan_done,
    output logic              overlap_err
);

    localparam int NOVW = (NONOVL < 1) ? 1 : $clog2(NONOVL + 1);
    localparam logic [NOVW-1:0] NOV_LOAD = NOVW'(NONOVL);

    logic [ROWS-1:0] sr_reg, sr_next;
    logic            dir_reg;
    logic            fr_reg;
    logic            blank_reg;
    logic [NOVW-1:0] nov_cnt_reg, nov_cnt_next;
    logic [IDXW-1:0] row_idx_reg, row_idx_next;
    logic            scan_done_reg;
    logic            overlap_err_reg;

    logic start;
    logic eff_dir;
    logic exit_bit;
    logic sel_en;

    assign start = st & shift_en;
    // A new scan uses the freshly presented direction for its very first shift.
    assign eff_dir  = start ? dir : dir_reg;
    assign exit_bit = eff_dir ? sr_reg[0] : sr_reg[ROWS-1];
    assign busy     = |sr_reg;

    always_comb begin
        sr_next = sr_reg;
        if (shift_en) begin
            if (eff_dir) sr_next = {st, sr_reg[ROWS-1:1]};
            else         sr_next = {sr_reg[ROWS-2:0], st};
        end
    end

    always_comb begin
        nov_cnt_next = nov_cnt_reg;
        if (shift_en)                nov_cnt_next = NOV_LOAD;
        else if (nov_cnt_reg != '0)  nov_cnt_next = nov_cnt_reg - NOVW'(1);
    end

    always_comb begin
        row_idx_next = row_idx_reg;
        if (start)                     row_idx_next = '0;
        else if (shift_en && exit_bit) row_idx_next = '0;
        else if (shift_en && busy)     row_idx_next = row_idx_reg + IDXW'(1);
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg          <= '0;
            dir_reg         <= 1'b0;
            fr_reg          <= 1'b0;
            blank_reg       <= 1'b0;
            nov_cnt_reg     <= '0;
            row_idx_reg     <= '0;
            scan_done_reg   <= 1'b0;
            overlap_err_reg <= 1'b0;
        end else begin
            sr_reg          <= sr_next;
            blank_reg       <= blank;
            nov_cnt_reg     <= nov_cnt_next;
            row_idx_reg     <= row_idx_next;
            scan_done_reg   <= shift_en & exit_bit;
            overlap_err_reg <= start & busy;
            if (start)    dir_reg <= dir;
            if (shift_en) fr_reg  <= fr;
        end
    end

    // Selects come only from registered state, so outputs have no input-to-output path.
    assign sel_en      = (nov_cnt_reg == '0) && !blank_reg;
    assign row_sel     = sr_reg & {ROWS{sel_en}};
    assign row_idx     = row_idx_reg;
    assign scan_done   = scan_done_reg;
    assign overlap_err = overlap_err_reg;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
            ydriver_scan_lvl u_lvl (
                .sel  (row_sel[gi]),
                .fr_q (fr_reg),
                .lvl  (lane_lvl[2*gi+1 -: 2])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ydriver_scan.sv
// Directed bench for ydriver_scan with ROWS=8, NONOVL=1.
module tb_ydriver_scan;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        st = 1'b0;
    logic        shift_en = 1'b0;
    logic        fr = 1'b0;
    logic        dir = 1'b0;
    logic        blank = 1'b0;
    logic [7:0]  row_sel;
    logic [15:0] lane_lvl;
    logic [2:0]  row_idx;
    logic        busy;
    logic        scan_done;
    logic        overlap_err;

    int checks = 0;
    int errors = 0;

    ydriver_scan #(.ROWS(8), .NONOVL(1)) dut (
        .ck          (ck),
        .rst_n       (rst_n),
        .st          (st),
        .shift_en    (shift_en),
        .fr          (fr),
        .dir         (dir),
        .blank       (blank),
        .row_sel     (row_sel),
        .lane_lvl    (lane_lvl),
        .row_idx     (row_idx),
        .busy        (busy),
        .scan_done   (scan_done),
        .overlap_err (overlap_err)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Expected lane codes: selected row {1,fr}, others {0,~fr}.
    function automatic logic [15:0] lvl_exp(input logic [7:0] sel, input logic f);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[2*i+1] = sel[i];
            r[2*i]   = sel[i] ? f : ~f;
        end
        return r;
    endfunction

    // One row strobe plus three idle cycles, with checks of the gap and the settled row.
    task automatic step(input logic s, input logic f, input logic d,
                        input logic [7:0] exp_sel, input logic [2:0] exp_idx,
                        input logic exp_done, input logic exp_ovl);
        st = s; fr = f; dir = d; shift_en = 1'b1;
        tick();
        shift_en = 1'b0; st = 1'b0;
        check("gap_row_sel", row_sel, 8'h00);
        check("scan_done", scan_done, exp_done);
        check("overlap_err", overlap_err, exp_ovl);
        tick();
        check("row_sel", row_sel, exp_sel);
        check("row_idx", row_idx, exp_idx);
        check("lane_lvl", lane_lvl, lvl_exp(exp_sel, f));
        check("busy", busy, exp_sel != 8'h00);
        check("scan_done_clr", scan_done, 1'b0);
        $display("strobe st=%0b fr=%0b dir=%0b row_sel=%02h row_idx=%0d lane_lvl=%04h",
                 s, f, d, row_sel, row_idx, lane_lvl);
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_row_sel", row_sel, 8'h00);
        check("rst_lane_lvl", lane_lvl, 16'h5555);
        #3 rst_n = 1'b1;
        tick();
        tick();
        check("idle_row_sel", row_sel, 8'h00);
        check("idle_lane_lvl", lane_lvl, 16'h5555);
        check("idle_busy", busy, 1'b0);
        check("idle_row_idx", row_idx, 3'd0);

        // Forward scan, fr=1
        step(1'b1, 1'b1, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++)
            step(1'b0, 1'b1, 1'b0, (k < 8) ? 8'(1 << k) : 8'h00,
                 (k < 8) ? 3'(k) : 3'd0, k == 8, 1'b0);

        // Reverse scan, fr=0
        step(1'b1, 1'b0, 1'b1, 8'h80, 3'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++)
            step(1'b0, 1'b0, 1'b1, (k < 8) ? 8'(8'h80 >> k) : 8'h00,
                 (k < 8) ? 3'(k) : 3'd0, k == 8, 1'b0);

        // Forward scan with dir toggled mid-scan (ignored), blank at row 3
        step(1'b1, 1'b1, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h02, 3'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h04, 3'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h08, 3'd3, 1'b0, 1'b0);
        blank = 1'b1;
        tick();
        check("blank1_row_sel", row_sel, 8'h00);
        check("blank1_row_idx", row_idx, 3'd3);
        tick();
        check("blank2_row_sel", row_sel, 8'h00);
        check("blank2_busy", busy, 1'b1);
        blank = 1'b0;
        tick();
        check("unblank_row_sel", row_sel, 8'h08);
        check("unblank_row_idx", row_idx, 3'd3);
        step(1'b0, 1'b1, 1'b0, 8'h10, 3'd4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h20, 3'd5, 1'b0, 1'b0);

        // Second start while busy: two tokens, index restarts
        step(1'b1, 1'b1, 1'b0, 8'h41, 3'd0, 1'b0, 1'b1);

        // Clear via reset, then back-to-back strobes keep selects suppressed
        #3 rst_n = 1'b0;
        #1;
        check("clr_busy", busy, 1'b0);
        tick();
        #3 rst_n = 1'b1;
        tick();
        st = 1'b1; fr = 1'b1; dir = 1'b0; shift_en = 1'b1;
        tick();
        st = 1'b0;
        check("held1_row_sel", row_sel, 8'h00);
        tick();
        check("held2_row_sel", row_sel, 8'h00);
        check("held2_row_idx", row_idx, 3'd1);
        shift_en = 1'b0;
        tick();
        check("held_release_row_sel", row_sel, 8'h02);
        tick();
        tick();
        step(1'b0, 1'b1, 1'b0, 8'h04, 3'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h08, 3'd3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h10, 3'd4, 1'b0, 1'b0);

        // fr changes between strobes must not reach lane_lvl
        fr = 1'b0;
        tick();
        check("fr_hold_lane_lvl", lane_lvl, 16'h0300);

        // Asynchronous reset mid-scan at row 4
        #3 rst_n = 1'b0;
        #1;
        check("arst_row_sel", row_sel, 8'h00);
        check("arst_busy", busy, 1'b0);
        check("arst_lane_lvl", lane_lvl, 16'h5555);
        check("arst_row_idx", row_idx, 3'd0);
        tick();
        check("arst_scan_done", scan_done, 1'b0);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_scan_done", scan_done, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
